// File: rtl/rv32imf_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32imf_div_pkg
// Description : Shared types and constants for the RV32M divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32imf_div_pkg;

  // Opcode: bit 0 selects signed, bit 1 selects remainder
  typedef enum logic [1:0] {
    OP_DIVU = 2'b00,
    OP_DIV  = 2'b01,
    OP_REMU = 2'b10,
    OP_REM  = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } div_ctrl_state_e;

  // Widest datapath this package supports; users slice the low bits
  localparam int unsigned C_DIV_MAX_W = 64;

  // Quotient returned for a divide by zero (all ones)
  localparam logic [C_DIV_MAX_W-1:0] C_DIV_ZERO_Q = '1;

endpackage : rv32imf_div_pkg
`default_nettype wire

// File: rtl/rv32imf_div_lzc.sv
`default_nettype none
// ============================================================================
// Module      : rv32imf_div_lzc
// Description : Leading-zero counter; reports C_WIDTH for an all-zero input.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32imf_div_lzc #(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = 6
) (
  input  logic [C_WIDTH-1:0]     i_data,
  output logic [C_LOG_WIDTH-1:0] o_cnt,
  output logic                   o_all_zero
);

  // Scan from LSB upward so the highest set bit determines the count
  always_comb begin
    o_cnt = C_LOG_WIDTH'(C_WIDTH);
    for (int i = 0; i < int'(C_WIDTH); i++) begin
      if (i_data[i]) begin
        o_cnt = C_LOG_WIDTH'(int'(C_WIDTH) - 1 - i);
      end
    end
  end

  assign o_all_zero = ~|i_data;

endmodule : rv32imf_div_lzc
`default_nettype wire

// File: rtl/rv32imf_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv32imf_div_ctrl
// Description : Sequencing front-end for the iterative RV32M divider. Accepts
//               tagged DIV/DIVU/REM/REMU requests, normalises the divisor,
//               resolves divide-by-zero and signed overflow without the
//               divider, and returns tagged results. Flushes during a divide
//               drain the divider's eventual result.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32imf_div_ctrl
  import rv32imf_div_pkg::*;
#(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = 6,
  parameter int unsigned C_TAG_W     = 5
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RI,
  input  logic                   Flush_SI,
  input  logic                   ReqVld_SI,
  output logic                   ReqRdy_SO,
  input  logic [1:0]             ReqOp_SI,
  input  logic [C_WIDTH-1:0]     ReqOpA_DI,
  input  logic [C_WIDTH-1:0]     ReqOpB_DI,
  input  logic [C_TAG_W-1:0]     ReqTag_DI,
  output logic                   RespVld_SO,
  input  logic                   RespRdy_SI,
  output logic [C_WIDTH-1:0]     RespRes_DO,
  output logic [C_TAG_W-1:0]     RespTag_DO,
  output logic [C_WIDTH-1:0]     DivOpA_DO,
  output logic [C_WIDTH-1:0]     DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                   DivOpBIsZero_SO,
  output logic                   DivOpBSign_SO,
  output logic [1:0]             DivOpCode_SO,
  output logic                   DivInVld_SO,
  output logic                   DivOutRdy_SO,
  input  logic                   DivOutVld_SI,
  input  logic [C_WIDTH-1:0]     DivRes_DI,
  output logic                   Busy_SO
);

  localparam logic [C_WIDTH-1:0] C_ALL_ONES = C_DIV_ZERO_Q[C_WIDTH-1:0];
  localparam logic [C_WIDTH-1:0] C_MIN_INT  = {1'b1, {(C_WIDTH-1){1'b0}}};

  div_ctrl_state_e r_state;
  logic [1:0]             r_op;
  logic [C_WIDTH-1:0]     r_opa;
  logic [C_WIDTH-1:0]     r_opb;
  logic [C_LOG_WIDTH-1:0] r_shift;
  logic                   r_bzero;
  logic                   r_bsign;
  logic [C_WIDTH-1:0]     r_res;
  logic [C_TAG_W-1:0]     r_tag;

  div_op_e                w_op;
  logic                   w_signed;
  logic                   w_b_neg;
  logic [C_WIDTH-1:0]     w_m;
  logic [C_LOG_WIDTH-1:0] w_lz;
  logic                   w_m_zero;
  logic                   w_b_zero;
  logic                   w_ovf;
  logic [C_LOG_WIDTH-1:0] w_shift;
  logic [C_WIDTH-1:0]     w_opb_norm;
  logic [C_WIDTH-1:0]     w_fast_res;
  logic                   w_accept;

  assign w_op     = div_op_e'(ReqOp_SI);
  assign w_signed = ReqOp_SI[0];
  assign w_b_neg  = w_signed & ReqOpB_DI[C_WIDTH-1];
  assign w_m      = w_b_neg ? ~ReqOpB_DI : ReqOpB_DI;

  rv32imf_div_lzc #(
    .C_WIDTH     (C_WIDTH),
    .C_LOG_WIDTH (C_LOG_WIDTH)
  ) u_lzc (
    .i_data     (w_m),
    .o_cnt      (w_lz),
    .o_all_zero (w_m_zero)
  );

  // A zero M with a negative B means B was all ones, not zero
  assign w_b_zero = w_m_zero & ~w_b_neg;
  assign w_ovf    = w_signed & (ReqOpA_DI == C_MIN_INT) & (&ReqOpB_DI);

  // Signed divisors keep one sign bit, so back the shift off by one
  always_comb begin
    w_shift = w_lz;
    if (w_signed) begin
      w_shift = (w_lz == '0) ? '0 : (w_lz - C_LOG_WIDTH'(1));
    end
  end

  assign w_opb_norm = ReqOpB_DI << w_shift;

  // Fast-path result for divide by zero or signed overflow
  always_comb begin
    w_fast_res = '0;
    case (w_op)
      OP_DIVU, OP_DIV: w_fast_res = w_b_zero ? C_ALL_ONES : C_MIN_INT;
      OP_REMU, OP_REM: w_fast_res = w_b_zero ? ReqOpA_DI  : '0;
      default:         w_fast_res = '0;
    endcase
  end

  assign w_accept = ReqVld_SI & ~Flush_SI & (r_state == S_IDLE);

  // Sequencer: captures requests, tracks the divider, holds the response
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_shift <= '0;
      r_bzero <= 1'b0;
      r_bsign <= 1'b0;
      r_res   <= '0;
      r_tag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= ReqOp_SI;
            r_opa   <= ReqOpA_DI;
            r_opb   <= w_opb_norm;
            r_shift <= w_shift;
            r_bzero <= w_b_zero;
            r_bsign <= w_b_neg;
            r_tag   <= ReqTag_DI;
            r_res   <= w_fast_res;
            r_state <= (w_b_zero | w_ovf) ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= Flush_SI ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          // The divider cannot be aborted, so a flush must still drain it
          if (Flush_SI) begin
            r_state <= S_DRAIN;
          end else if (DivOutVld_SI) begin
            r_res   <= DivRes_DI;
            r_state <= S_RESP;
          end
        end
        S_DRAIN: begin
          if (DivOutVld_SI) begin
            r_state <= S_IDLE;
          end
        end
        S_RESP: begin
          if (Flush_SI || RespRdy_SI) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ReqRdy_SO       = (r_state == S_IDLE) & ~Flush_SI;
  assign RespVld_SO      = (r_state == S_RESP) & ~Flush_SI;
  assign RespRes_DO      = r_res;
  assign RespTag_DO      = r_tag;
  assign DivOpA_DO       = r_opa;
  assign DivOpB_DO       = r_opb;
  assign DivOpBShift_DO  = r_shift;
  assign DivOpBIsZero_SO = r_bzero;
  assign DivOpBSign_SO   = r_bsign;
  assign DivOpCode_SO    = r_op;
  assign DivInVld_SO     = (r_state == S_ISSUE) & ~Flush_SI;
  // In WAIT a flush defers the accept to DRAIN so the result is taken once
  assign DivOutRdy_SO    = DivOutVld_SI &
                           (((r_state == S_WAIT) & ~Flush_SI) | (r_state == S_DRAIN));
  assign Busy_SO         = (r_state != S_IDLE);

endmodule : rv32imf_div_ctrl
`default_nettype wire

// File: tb/tb_rv32imf_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32imf_div_ctrl
// Description : Scoreboard bench for rv32imf_div_ctrl with a simple divider
//               model that returns a preset result after a set latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32imf_div_ctrl;

  logic        Clk_CI = 1'b0;
  logic        Rst_RI;
  logic        Flush_SI;
  logic        ReqVld_SI;
  logic        ReqRdy_SO;
  logic [1:0]  ReqOp_SI;
  logic [31:0] ReqOpA_DI;
  logic [31:0] ReqOpB_DI;
  logic [4:0]  ReqTag_DI;
  logic        RespVld_SO;
  logic        RespRdy_SI;
  logic [31:0] RespRes_DO;
  logic [4:0]  RespTag_DO;
  logic [31:0] DivOpA_DO;
  logic [31:0] DivOpB_DO;
  logic [5:0]  DivOpBShift_DO;
  logic        DivOpBIsZero_SO;
  logic        DivOpBSign_SO;
  logic [1:0]  DivOpCode_SO;
  logic        DivInVld_SO;
  logic        DivOutRdy_SO;
  logic        DivOutVld_SI;
  logic [31:0] DivRes_DI;
  logic        Busy_SO;

  rv32imf_div_ctrl dut (
    .Clk_CI          (Clk_CI),
    .Rst_RI          (Rst_RI),
    .Flush_SI        (Flush_SI),
    .ReqVld_SI       (ReqVld_SI),
    .ReqRdy_SO       (ReqRdy_SO),
    .ReqOp_SI        (ReqOp_SI),
    .ReqOpA_DI       (ReqOpA_DI),
    .ReqOpB_DI       (ReqOpB_DI),
    .ReqTag_DI       (ReqTag_DI),
    .RespVld_SO      (RespVld_SO),
    .RespRdy_SI      (RespRdy_SI),
    .RespRes_DO      (RespRes_DO),
    .RespTag_DO      (RespTag_DO),
    .DivOpA_DO       (DivOpA_DO),
    .DivOpB_DO       (DivOpB_DO),
    .DivOpBShift_DO  (DivOpBShift_DO),
    .DivOpBIsZero_SO (DivOpBIsZero_SO),
    .DivOpBSign_SO   (DivOpBSign_SO),
    .DivOpCode_SO    (DivOpCode_SO),
    .DivInVld_SO     (DivInVld_SO),
    .DivOutRdy_SO    (DivOutRdy_SO),
    .DivOutVld_SI    (DivOutVld_SI),
    .DivRes_DI       (DivRes_DI),
    .Busy_SO         (Busy_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   issue_cnt = 0;
  int   ordy_cnt = 0;
  int   resp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] res, input logic [4:0] tag);
    exp_t e;
    e.res = res;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Divider model: reports valid while idle, busy for dv_lat cycles after issue
  logic        dv_busy;
  int          dv_cnt;
  logic [31:0] dv_res;
  logic [31:0] dv_next_res = 32'h0;
  int          dv_lat = 4;

  always @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      dv_busy <= 1'b0;
      dv_cnt  <= 0;
      dv_res  <= 32'h0BAD0BAD;
    end else if (DivInVld_SO) begin
      dv_busy <= 1'b1;
      dv_cnt  <= dv_lat;
      dv_res  <= dv_next_res;
    end else if (dv_busy && dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 1;
    end else if (dv_busy && DivOutRdy_SO) begin
      dv_busy <= 1'b0;
      dv_res  <= 32'h0BAD0BAD;
    end
  end

  assign DivOutVld_SI = !dv_busy || (dv_cnt == 0);
  assign DivRes_DI    = dv_res;

  // Handshake counters
  always @(posedge Clk_CI) begin
    if (!Rst_RI && DivInVld_SO)  issue_cnt <= issue_cnt + 1;
    if (!Rst_RI && DivOutRdy_SO) ordy_cnt  <= ordy_cnt + 1;
  end

  // Monitor: compare every accepted response against the scoreboard
  always @(negedge Clk_CI) begin
    if (!Rst_RI && RespVld_SO && RespRdy_SI) begin
      resp_cnt <= resp_cnt + 1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL resp_unexpected: got res 0x%08h tag %0d, expected no response",
                 RespRes_DO, RespTag_DO);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_res", RespRes_DO, e.res);
        chk("resp_tag", {27'b0, RespTag_DO}, {27'b0, e.tag});
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
    bit ok;
    ok        = 1'b0;
    ReqVld_SI = 1'b1;
    ReqOp_SI  = op;
    ReqOpA_DI = a;
    ReqOpB_DI = b;
    ReqTag_DI = tag;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clk_CI);
      if (ReqRdy_SO) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_timeout: got ReqRdy 0, expected 1 within 200 cycles");
    end
    @(posedge Clk_CI);
    #1;
    ReqVld_SI = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clk_CI);
      if (!Busy_SO) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: got Busy 1, expected 0 within 200 cycles");
    end
    @(posedge Clk_CI);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ic, orc, rc;
    Rst_RI     = 1'b1;
    Flush_SI   = 1'b0;
    ReqVld_SI  = 1'b0;
    ReqOp_SI   = 2'b00;
    ReqOpA_DI  = '0;
    ReqOpB_DI  = '0;
    ReqTag_DI  = '0;
    RespRdy_SI = 1'b1;
    repeat (2) @(posedge Clk_CI);
    #1;
    chk("rst_reqrdy",  {31'b0, ReqRdy_SO},    32'd1);
    chk("rst_respvld", {31'b0, RespVld_SO},   32'd0);
    chk("rst_divin",   {31'b0, DivInVld_SO},  32'd0);
    chk("rst_divrdy",  {31'b0, DivOutRdy_SO}, 32'd0);
    chk("rst_busy",    {31'b0, Busy_SO},      32'd0);
    chk("rst_res",     RespRes_DO,            32'd0);
    Rst_RI = 1'b0;
    @(posedge Clk_CI);
    #1;

    // DIVU 100 / 7
    dv_next_res = 32'd14;
    push_exp(32'd14, 5'd3);
    ic = issue_cnt;
    do_req(2'b00, 32'd100, 32'd7, 5'd3);
    chk("divu_divin", {31'b0, DivInVld_SO}, 32'd1);
    chk("divu_opa",   DivOpA_DO, 32'd100);
    chk("divu_opb",   DivOpB_DO, 32'hE000_0000);
    chk("divu_shift", {26'b0, DivOpBShift_DO}, 32'd29);
    chk("divu_sign",  {31'b0, DivOpBSign_SO}, 32'd0);
    chk("divu_code",  {30'b0, DivOpCode_SO}, 32'd0);
    wait_idle();
    chk("divu_issue_once", 32'(issue_cnt - ic), 32'd1);

    // REM -7 % 2
    dv_next_res = 32'hFFFF_FFFF;
    push_exp(32'hFFFF_FFFF, 5'd9);
    do_req(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd9);
    chk("rem_sign",  {31'b0, DivOpBSign_SO}, 32'd0);
    chk("rem_shift", {26'b0, DivOpBShift_DO}, 32'd29);
    chk("rem_opb",   DivOpB_DO, 32'h4000_0000);
    chk("rem_code",  {30'b0, DivOpCode_SO}, 32'd3);
    wait_idle();

    // Fast path: divide by zero and signed overflow
    ic = issue_cnt;
    push_exp(32'hFFFF_FFFF, 5'd1);
    do_req(2'b01, 32'd5, 32'd0, 5'd1);
    chk("div0_fast_vld", {31'b0, RespVld_SO},  32'd1);
    chk("div0_no_issue", {31'b0, DivInVld_SO}, 32'd0);
    wait_idle();
    push_exp(32'd5, 5'd2);
    do_req(2'b10, 32'd5, 32'd0, 5'd2);
    chk("remu0_fast_vld", {31'b0, RespVld_SO}, 32'd1);
    wait_idle();
    push_exp(32'h8000_0000, 5'd4);
    do_req(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    chk("ovf_div_fast_vld", {31'b0, RespVld_SO}, 32'd1);
    wait_idle();
    push_exp(32'h0, 5'd5);
    do_req(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
    chk("ovf_rem_fast_vld", {31'b0, RespVld_SO}, 32'd1);
    wait_idle();
    chk("fast_no_issue", 32'(issue_cnt - ic), 32'd0);

    // Flush three cycles into WAIT: divider result drained, no response
    dv_lat      = 12;
    dv_next_res = 32'h1234_5678;
    orc = ordy_cnt;
    rc  = resp_cnt;
    do_req(2'b00, 32'd1000, 32'd3, 5'd6);
    @(posedge Clk_CI);
    #1;
    repeat (3) @(posedge Clk_CI);
    #1;
    Flush_SI = 1'b1;
    @(posedge Clk_CI);
    #1;
    Flush_SI = 1'b0;
    chk("drain_busy",   {31'b0, Busy_SO},   32'd1);
    chk("drain_reqrdy", {31'b0, ReqRdy_SO}, 32'd0);
    wait_idle();
    chk("drain_outrdy_once", 32'(ordy_cnt - orc), 32'd1);
    chk("drain_no_resp",     32'(resp_cnt - rc),  32'd0);
    dv_lat      = 4;
    dv_next_res = 32'd10;
    push_exp(32'd10, 5'd8);
    do_req(2'b00, 32'd50, 32'd5, 5'd8);
    wait_idle();

    // Back-pressure: response held stable for five cycles
    RespRdy_SI = 1'b0;
    push_exp(32'hFFFF_FFFF, 5'd7);
    do_req(2'b01, 32'd9, 32'd0, 5'd7);
    for (int k = 0; k < 5; k++) begin
      chk("hold_vld",    {31'b0, RespVld_SO}, 32'd1);
      chk("hold_res",    RespRes_DO, 32'hFFFF_FFFF);
      chk("hold_tag",    {27'b0, RespTag_DO}, 32'd7);
      chk("hold_reqrdy", {31'b0, ReqRdy_SO}, 32'd0);
      @(posedge Clk_CI);
      #1;
    end
    RespRdy_SI = 1'b1;
    wait_idle();

    // Asynchronous reset mid-WAIT
    dv_lat = 20;
    do_req(2'b00, 32'd100, 32'd7, 5'd11);
    repeat (3) @(posedge Clk_CI);
    #2;
    Rst_RI = 1'b1;
    #1;
    chk("arst_busy",    {31'b0, Busy_SO},      32'd0);
    chk("arst_reqrdy",  {31'b0, ReqRdy_SO},    32'd1);
    chk("arst_respvld", {31'b0, RespVld_SO},   32'd0);
    chk("arst_divrdy",  {31'b0, DivOutRdy_SO}, 32'd0);
    chk("arst_res",     RespRes_DO,            32'd0);
    chk("arst_tag",     {27'b0, RespTag_DO},   32'd0);
    chk("arst_opb",     DivOpB_DO,             32'd0);
    @(posedge Clk_CI);
    #1;
    Rst_RI = 1'b0;
    @(posedge Clk_CI);
    #1;

    // Recovery after reset
    dv_lat      = 4;
    dv_next_res = 32'd14;
    push_exp(32'd14, 5'd12);
    do_req(2'b00, 32'd100, 32'd7, 5'd12);
    wait_idle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rv32imf_div_ctrl
`default_nettype wire
